// File: rtl/mem_control.sv
// Shared asynchronous SRAM controller behind the MEM stage: zero-cycle instruction fetch,
// one-cycle loads, three-cycle WE store sequence and memory-mapped UART data/status registers.
module mem_control #(
  parameter int          SRAM_AW        = 18,
  parameter logic [15:0] NOP_INST       = 16'h0800,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        memAddr_i,
  input  logic [15:0]        wData_mem_i,
  input  logic               rMem_i,
  input  logic               wMem_i,
  output logic [15:0]        rData_o,
  input  logic [15:0]        if_addr_i,
  output logic [15:0]        inst_o,
  output logic               stall_request_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [15:0]        sram_data_o,
  input  logic [15:0]        sram_data_i,
  output logic               sram_data_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [7:0]         uart_tx_data_o,
  output logic               uart_tx_valid_o,
  input  logic               uart_tx_ready_i,
  input  logic [7:0]         uart_rx_data_i,
  input  logic               uart_rx_ready_i,
  output logic               uart_rx_ack_o
);

  typedef enum logic [2:0] {IDLE, RD, W1, W2, W3} state_t;

  state_t state;

  logic is_uart_data;
  logic is_uart_stat;
  logic is_sram;

  assign is_uart_data = (memAddr_i == UART_DATA_ADDR);
  assign is_uart_stat = (memAddr_i == UART_STAT_ADDR);
  assign is_sram      = !is_uart_data && !is_uart_stat;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (wMem_i)      state <= W1;
          else if (rMem_i) state <= RD;
        end
        RD:      state <= IDLE;
        W1:      state <= W2;
        W2:      state <= W3;
        W3:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus and pipeline outputs are decoded from the current state so fetch and loads see the
  // asynchronous SRAM in the same cycle; reset forces the idle bus values in the reset cycle.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    rData_o         = '0;
    inst_o          = NOP_INST;
    stall_request_o = 1'b0;
    sram_addr_o     = {{(SRAM_AW-16){1'b0}}, memAddr_i};
    sram_data_o     = wData_mem_i;
    sram_data_oe    = 1'b0;
    sram_ce_n       = 1'b1;
    sram_oe_n       = 1'b1;
    sram_we_n       = 1'b1;
    uart_tx_data_o  = wData_mem_i[7:0];
    uart_tx_valid_o = 1'b0;
    uart_rx_ack_o   = 1'b0;

    if (!rst) begin
      case (state)
        IDLE: begin
          if (rMem_i || wMem_i) begin
            stall_request_o = 1'b1;
          end else begin
            sram_addr_o = {{(SRAM_AW-16){1'b0}}, if_addr_i};
            sram_ce_n   = 1'b0;
            sram_oe_n   = 1'b0;
            inst_o      = sram_data_i;
          end
        end
        RD: begin
          if (is_uart_data) begin
            rData_o       = {8'h00, uart_rx_data_i};
            uart_rx_ack_o = 1'b1;
          end else if (is_uart_stat) begin
            rData_o = {14'b0, uart_rx_ready_i, uart_tx_ready_i};
          end else begin
            sram_ce_n = 1'b0;
            sram_oe_n = 1'b0;
            rData_o   = sram_data_i;
          end
        end
        W1: begin
          stall_request_o = 1'b1;
          if (is_uart_data) begin
            uart_tx_valid_o = 1'b1;
          end else if (is_sram) begin
            sram_ce_n    = 1'b0;
            sram_data_oe = 1'b1;
          end
        end
        W2: begin
          stall_request_o = 1'b1;
          if (is_sram) begin
            sram_ce_n    = 1'b0;
            sram_data_oe = 1'b1;
            sram_we_n    = 1'b0;
          end
        end
        W3: begin
          // Data stays driven one more cycle after we_n rises for SRAM hold time.
          if (is_sram) begin
            sram_ce_n    = 1'b0;
            sram_data_oe = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
